// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel pulse generator.
// Latency: n/a (types, constants and helper function only).
// Backpressure: n/a.
package multi_pulse_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Shadow values loaded at reset (the default period is a top-level parameter)
    localparam int DEF_WIDTH = 1;
    localparam int DEF_BURST = 0;

    // Width of the channel index on the config port; never narrower than one bit
    function automatic int CH_IDX_W(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: shadow/active config, period counter, burst countdown, IDLE/RUN FSM.
// Latency: start/stop take effect at the next edge; pulse_out/busy are decoded combinationally from registers.
// Backpressure: none; done is a single-cycle strobe that is raised during the final cycle of a burst.
module pulse_gen_channel
    import multi_pulse_gen_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int BURST_W    = 8,
    parameter int DEF_PERIOD = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               pulse_out,
    output logic               busy,
    output logic               done
);

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   sh_period;
    logic [CNT_W-1:0]   sh_width;
    logic [BURST_W-1:0] sh_burst;
    logic [CNT_W-1:0]   act_period;
    logic [CNT_W-1:0]   act_width;
    logic [CNT_W-1:0]   counter;
    logic [BURST_W-1:0] remaining;
    logic [CNT_W-1:0]   eff_period;
    logic               in_run;
    logic               wrap;
    logic               last_wrap;

    // A programmed period of 0 behaves as a period of 1
    assign in_run     = (state == ST_RUN);
    assign eff_period = (act_period == '0) ? CNT_W'(1) : act_period;
    assign wrap       = (counter == eff_period - CNT_W'(1));
    // Final wrap of a burst; remaining == 0 means continuous, so it never matches
    assign last_wrap  = in_run && wrap && (remaining == BURST_W'(1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: stop beats start, start beats burst exhaustion
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !stop) state_nxt = ST_RUN;
            ST_RUN: begin
                if (stop)           state_nxt = ST_IDLE;
                else if (start)     state_nxt = ST_RUN;
                else if (last_wrap) state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; done is suppressed when a start or stop overrides the burst end
    always_comb begin
        busy      = in_run;
        pulse_out = in_run && (counter < act_width);
        done      = last_wrap && !start && !stop;
    end

    // Shadow registers written from the config port
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_period <= CNT_W'(DEF_PERIOD);
            sh_width  <= CNT_W'(DEF_WIDTH);
            sh_burst  <= BURST_W'(DEF_BURST);
        end else if (cfg_we) begin
            sh_period <= cfg_period;
            sh_width  <= cfg_width;
            sh_burst  <= cfg_burst;
        end
    end

    // Active config follows shadow while idle, and is refreshed on start or period wrap while running
    always_ff @(posedge clk) begin
        if (reset) begin
            act_period <= CNT_W'(DEF_PERIOD);
            act_width  <= CNT_W'(DEF_WIDTH);
        end else if (!in_run || start || wrap) begin
            act_period <= sh_period;
            act_width  <= sh_width;
        end
    end

    // Period counter and burst countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            remaining <= '0;
        end else if (state_nxt == ST_IDLE) begin
            counter   <= '0;
            remaining <= '0;
        end else if (start) begin
            counter   <= '0;
            remaining <= sh_burst;
        end else if (wrap) begin
            counter <= '0;
            if (remaining > BURST_W'(1)) remaining <= remaining - BURST_W'(1);
        end else begin
            counter <= counter + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel programmable pulse generator with indexed config port; optional sticky IRQ (MULTI_PULSE_GEN_IRQ_EN).
// Latency: config lands in shadow at the next edge; start/stop act at the next edge; outputs decode from registers.
// Backpressure: none; out-of-range cfg_ch writes are dropped, irq flags hold until cleared.
module multi_pulse_generator
    import multi_pulse_gen_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 16,
    parameter int BURST_W    = 8,
    parameter int DEF_PERIOD = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [CH_IDX_W(CHANNELS)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]                cfg_period,
    input  logic [CNT_W-1:0]                cfg_width,
    input  logic [BURST_W-1:0]              cfg_burst,
    input  logic [CHANNELS-1:0]             start,
    input  logic [CHANNELS-1:0]             stop,
`ifdef MULTI_PULSE_GEN_IRQ_EN
    input  logic [CHANNELS-1:0]             irq_clr,
    output logic                            irq,
`endif
    output logic [CHANNELS-1:0]             pulse_out,
    output logic [CHANNELS-1:0]             busy,
    output logic [CHANNELS-1:0]             done
);

    localparam int CH_W = CH_IDX_W(CHANNELS);

    logic [CHANNELS-1:0] ch_we;

    // Config write decode; an index with no matching channel selects nothing
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pulse_gen_channel #(
            .CNT_W      (CNT_W),
            .BURST_W    (BURST_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cfg_we     (ch_we[g]),
            .cfg_period (cfg_period),
            .cfg_width  (cfg_width),
            .cfg_burst  (cfg_burst),
            .start      (start[g]),
            .stop       (stop[g]),
            .pulse_out  (pulse_out[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

`ifdef MULTI_PULSE_GEN_IRQ_EN
    logic [CHANNELS-1:0] irq_flag;

    // Sticky completion flags; a new done wins over a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag <= '0;
        end else begin
            irq_flag <= (irq_flag & ~irq_clr) | done;
        end
    end

    assign irq = |irq_flag;
`endif

endmodule
